router_1xn: RTL and testbench
=============================

Name: router_1xn

Overview:
- Parametrised 1-to-N packet router and the successor to the fixed 1x3 router.
- Accepts byte-serial packets on one input: a header beat, then payload beats, then a parity beat.
- Routes each packet into one of N_CH output FIFOs.
- New behaviour over the 1x3 router:
  - Admission is based on free space in the destination FIFO, not on the FIFO being empty.
  - Per-channel read-timeout flush.
  - Invalid-address and oversize packets are dropped and flagged.
  - Parameterised data width, channel count and depth.

Parameters:
- DW, 8: data/beat width in bits.
- N_CH, 3: number of output channels, 2..16.
- AW, $clog2(N_CH): address field width; occupies header bits [AW-1:0].
- DEPTH, 64: entries per channel FIFO; must be a power of two, at least 4.
- TIMEOUT, 30: cycles a channel may sit non-empty with no read before it is flushed.

Ports:
- clk  in  1  system clock; every flop is rising-edge triggered.
- rst  in  1  asynchronous, active-low reset.
- d_in  in  DW  input beat: header, payload or parity.
- pkt_valid  in  1  high during header and payload beats; low during the parity beat.
- rd_en  in  N_CH  per-channel read request.
- vld_out  out  N_CH  per-channel FIFO-not-empty indication.
- dout  out  N_CH*DW  channel i data is at bits [i*DW +: DW]; registered.
- busy  out  1  sender must hold the current beat while this is high.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all FIFO pointers and counts go to 0; timeout counters go to 0.
  - vld_out=0, dout=0, err=0, busy=0.
  - Reset asserted mid-packet abandons the packet; nothing partial survives.
- Header fields:
  - addr = d_in[AW-1:0].
  - len = d_in[DW-1:AW], the payload beat count, 0..2^(DW-AW)-1.
  - need = len+2 (header + payload + parity are all stored in the FIFO).
- Beat acceptance: a beat is accepted on a rising edge where the FSM expects it and busy=0.
- FSM states: IDLE, PAYLOAD, PARITY, DISCARD.
- IDLE:
  - If pkt_valid=1 and addr >= N_CH: header consumed, go to DISCARD.
  - Else if need > DEPTH (oversize): header consumed, go to DISCARD.
  - Else if the destination's free entries are fewer than need: busy=1 (combinational), header is not consumed, stay in IDLE.
  - Else: header written to the destination FIFO; go to PAYLOAD, or to PARITY if len=0.
  - Free-space count includes reads and flushes in the same cycle only from the next cycle on.
- PAYLOAD:
  - Each beat is written and XOR-accumulated.
  - After len beats, go to PARITY.
  - No stall is possible, because space was reserved at admission.
- PARITY:
  - The beat is written.
  - err pulses the next cycle if it does not equal the XOR of the header and all payload beats, or if pkt_valid=1 on this beat.
  - Go to IDLE.
- DISCARD:
  - Consumes beats with nothing written.
  - Length is known for oversize packets (len+1 more beats), so the FSM counts them.
  - For invalid addresses, length is also taken from the header.
  - On the final beat: err pulses, go to IDLE.
- Read side:
  - vld_out[i] = FIFO i not empty.
  - rd_en[i]=1 with vld_out[i]=1 at an edge: dout[i] loads the head entry and the pointer advances.
  - Otherwise dout holds its value. rd_en on an empty FIFO is ignored.
- Simultaneous read and write on the same FIFO: both happen and the count is unchanged.
- Timeout:
  - Counter i increments each cycle vld_out[i]=1 and rd_en[i]=0; it clears on any read or when the FIFO is empty.
  - When the counter reaches TIMEOUT, FIFO i is flushed on the next edge (pointers to 0) and the counter clears. dout[i] holds its value.
  - If the packet being written targets the flushed channel, the write in that cycle is dropped, the FSM moves to DISCARD for the remaining beats, and err pulses at packet end.
- err is never asserted for more than one cycle per packet.

Test Plan:
- N_CH=3, DEPTH=64: header 8'h20 (len=8, addr=0), 8 payload beats, correct parity, then rd_en[0] held high → FIFO 0 holds 10 entries; dout_0 shows the header, payloads and parity in order; err stays 0; vld_out[0] falls after the 10th read.
- Same packet with parity corrupted to 8'h28 → err is high for exactly one cycle after the parity beat; the FIFO still contains 10 entries.
- Fill channel 1 to 60 entries, then offer a len=16 header (need=18) → busy=1 and the header is held. Read 14 entries → busy drops the next cycle and the packet is accepted.
- Header with addr=3 (N_CH=3) and len=4 → busy stays 0, 5 more beats are consumed, no FIFO changes, one err pulse.
- Load channel 2 with a len=2 packet and never read it → at cycle TIMEOUT+1 after vld_out[2] rises, vld_out[2] goes to 0; other channels are unaffected.
- Assert rst low mid-payload on channel 0 → immediately vld_out=0, busy=0, err=0; a following packet is routed normally.

Source files
------------

// File: rtl/router_1xn_if.sv
// Beat input, per-channel read/valid/data and status bundle for router_1xn.
// The slave modport is the router side; master is the source/reader side.
interface router_1xn_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned N_CH = 3
);
  logic [DW-1:0]      d_in;
  logic               pkt_valid;
  logic [N_CH-1:0]    rd_en;
  logic [N_CH-1:0]    vld_out;
  logic [N_CH*DW-1:0] dout;
  logic               busy;
  logic               err;

  modport master (output d_in, pkt_valid, rd_en, input vld_out, dout, busy, err);
  modport slave  (input d_in, pkt_valid, rd_en, output vld_out, dout, busy, err);
endinterface

// File: rtl/router_1xn.sv
// 1-to-N byte-serial packet router: header/payload/parity beats are routed into
// per-channel FIFOs with space-based admission, parity check and read-timeout flush.
module router_1xn #(
  parameter int unsigned DW      = 8,
  parameter int unsigned N_CH    = 3,
  parameter int unsigned AW      = $clog2(N_CH),
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic         clk,
  input  logic         rst,
  router_1xn_if.slave  bus
);

  localparam int unsigned LW = DW - AW;
  localparam int unsigned RW = LW + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   dest_q, dest_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   par_q, par_d;
  logic            err_q, err_d;
  logic            busy;

  logic [DW-1:0]   mem_q  [N_CH][DEPTH];
  logic [CW-1:0]   cnt_q  [N_CH];
  logic [CW-1:0]   cnt_d  [N_CH];
  logic [PW-1:0]   wptr_q [N_CH];
  logic [PW-1:0]   wptr_d [N_CH];
  logic [PW-1:0]   rptr_q [N_CH];
  logic [PW-1:0]   rptr_d [N_CH];
  logic [TW-1:0]   tmo_q  [N_CH];
  logic [TW-1:0]   tmo_d  [N_CH];
  logic [DW-1:0]   dout_q [N_CH];
  logic [DW-1:0]   dout_d [N_CH];

  logic [N_CH-1:0]    wr_en, rd_fire, flush, vld;
  logic [N_CH*DW-1:0] dout_flat;

  logic [AW-1:0] hdr_addr, hdr_idx;
  logic [LW-1:0] hdr_len;
  logic [RW-1:0] hdr_need;
  logic          addr_ok, oversize, space_ok;

  always_comb begin
    hdr_addr = bus.d_in[AW-1:0];
    hdr_len  = bus.d_in[DW-1:AW];
    hdr_need = RW'(hdr_len) + RW'(2);
    addr_ok  = 32'(hdr_addr) < N_CH;
    oversize = 32'(hdr_need) > DEPTH;
    hdr_idx  = addr_ok ? hdr_addr : '0;
    space_ok = (32'(cnt_q[hdr_idx]) + 32'(hdr_need)) <= DEPTH;
  end

  always_comb begin
    flush = '0;
    vld   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      flush[i] = tmo_q[i] == TW'(TIMEOUT);
      vld[i]   = cnt_q[i] != '0;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    rem_d   = rem_q;
    par_d   = par_q;
    err_d   = 1'b0;
    busy    = 1'b0;
    wr_en   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          if (!addr_ok || oversize) begin
            state_d = DISCARD;
            rem_d   = RW'(hdr_len) + RW'(1);
          end else if (!space_ok) begin
            busy = 1'b1;
          end else begin
            dest_d = hdr_addr;
            par_d  = bus.d_in;
            rem_d  = RW'(hdr_len);
            if (flush[hdr_addr]) begin
              state_d = DISCARD;
              rem_d   = RW'(hdr_len) + RW'(1);
            end else begin
              wr_en[hdr_addr] = 1'b1;
              state_d = (hdr_len == '0) ? PARITY : PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        par_d = par_q ^ bus.d_in;
        // rem_q already equals the beats left after this one (payload + parity)
        if (flush[dest_q]) begin
          state_d = DISCARD;
        end else begin
          wr_en[dest_q] = 1'b1;
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = PARITY;
        end
      end
      PARITY: begin
        state_d = IDLE;
        if (flush[dest_q]) begin
          err_d = 1'b1;
        end else begin
          wr_en[dest_q] = 1'b1;
          err_d = (bus.d_in != par_q) || bus.pkt_valid;
        end
      end
      DISCARD: begin
        rem_d = rem_q - RW'(1);
        if (rem_q == RW'(1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush takes priority over a same-cycle read so dout holds its value.
  always_comb begin
    rd_fire = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      rd_fire[i] = bus.rd_en[i] && vld[i] && !flush[i];
      if (flush[i]) begin
        cnt_d[i]  = '0;
        wptr_d[i] = '0;
        rptr_d[i] = '0;
      end else begin
        cnt_d[i]  = cnt_q[i] + CW'(wr_en[i]) - CW'(rd_fire[i]);
        wptr_d[i] = wptr_q[i] + PW'(wr_en[i]);
        rptr_d[i] = rptr_q[i] + PW'(rd_fire[i]);
      end
      dout_d[i] = rd_fire[i] ? mem_q[i][rptr_q[i]] : dout_q[i];
      tmo_d[i]  = (flush[i] || !vld[i] || bus.rd_en[i]) ? '0 : tmo_q[i] + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rem_q   <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        tmo_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      rem_q   <= rem_d;
      par_q   <= par_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        tmo_q[i]  <= tmo_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (wr_en[i]) mem_q[i][wptr_q[i]] <= bus.d_in;
    end
  end

  always_comb begin
    dout_flat = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      dout_flat[i*DW +: DW] = dout_q[i];
    end
  end

  assign bus.vld_out = vld;
  assign bus.dout    = dout_flat;
  assign bus.busy    = busy;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_router_1xn.sv
// Directed self-checking bench for router_1xn (N_CH=3, DEPTH=64, TIMEOUT=80).
module tb_router_1xn;
  localparam int unsigned TMO = 80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  router_1xn_if #(.DW(8), .N_CH(3)) bus ();

  router_1xn #(.DW(8), .N_CH(3), .DEPTH(64), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic pv);
    bus.d_in      = d;
    bus.pkt_valid = pv;
    tick();
  endtask

  task automatic idle();
    bus.d_in      = '0;
    bus.pkt_valid = 1'b0;
  endtask

  logic [7:0] exp_a [10];

  initial begin
    bus.d_in      = '0;
    bus.pkt_valid = 1'b0;
    bus.rd_en     = '0;
    exp_a = '{8'h20, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};

    // reset state
    #12;
    chk("rst_vld",  32'(bus.vld_out), 32'h0);
    chk("rst_dout", 32'(bus.dout),    32'h0);
    chk("rst_busy", 32'(bus.busy),    32'h0);
    chk("rst_err",  32'(bus.err),     32'h0);
    #5 rst = 1'b1;
    tick();

    // A: addr 0, len 8, good parity, then drain
    bus.d_in = 8'h20; bus.pkt_valid = 1'b1; #1;
    chk("A_busy", 32'(bus.busy), 32'h0);
    tick();
    for (int k = 0; k < 8; k++) beat(8'h10 + 8'(k), 1'b1);
    beat(8'h20, 1'b0);
    idle();
    chk("A_err", 32'(bus.err), 32'h0);
    chk("A_vld", 32'(bus.vld_out), 32'h1);
    bus.rd_en = 3'b001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("A_dout", 32'(bus.dout[7:0]), 32'(exp_a[i]));
      if (i == 8) chk("A_vld9", 32'(bus.vld_out[0]), 32'h1);
    end
    chk("A_vld10", 32'(bus.vld_out[0]), 32'h0);
    bus.rd_en = '0;

    // B: same packet, corrupted parity
    beat(8'h20, 1'b1);
    for (int k = 0; k < 8; k++) beat(8'h10 + 8'(k), 1'b1);
    beat(8'h28, 1'b0);
    idle();
    chk("B_err1", 32'(bus.err), 32'h1);
    tick();
    chk("B_err2", 32'(bus.err), 32'h0);
    bus.rd_en = 3'b001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 8) chk("B_vld9", 32'(bus.vld_out[0]), 32'h1);
    end
    chk("B_last", 32'(bus.dout[7:0]), 32'h28);
    chk("B_vld10", 32'(bus.vld_out[0]), 32'h0);
    bus.rd_en = '0;

    // C: fill channel 1 to 60 entries (len 58), then len 16 header must stall
    beat(8'hE9, 1'b1);
    for (int k = 0; k < 58; k++) beat(8'(k), 1'b1);
    beat(8'hE8, 1'b0);
    idle();
    chk("C_err", 32'(bus.err), 32'h0);
    chk("C_vld", 32'(bus.vld_out), 32'h2);
    bus.d_in = 8'h41; bus.pkt_valid = 1'b1; #1;
    chk("C_busy0", 32'(bus.busy), 32'h1);
    tick();
    tick();
    chk("C_busy2", 32'(bus.busy), 32'h1);
    bus.rd_en = 3'b010;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 12) chk("C_busy13", 32'(bus.busy), 32'h1);
    end
    chk("C_rd14", 32'(bus.dout[15:8]), 32'h0C);
    chk("C_busy14", 32'(bus.busy), 32'h0);
    bus.rd_en = '0;
    tick();
    for (int k = 0; k < 16; k++) beat(8'hA0 + 8'(k), 1'b1);
    beat(8'h41, 1'b0);
    idle();
    chk("C_err2", 32'(bus.err), 32'h0);
    bus.rd_en = 3'b010;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 0)  chk("C_d0",  32'(bus.dout[15:8]), 32'h0D);
      if (i == 45) chk("C_d45", 32'(bus.dout[15:8]), 32'hE8);
      if (i == 46) chk("C_d46", 32'(bus.dout[15:8]), 32'h41);
      if (i == 47) chk("C_d47", 32'(bus.dout[15:8]), 32'hA0);
      if (i == 63) chk("C_d63", 32'(bus.dout[15:8]), 32'h41);
    end
    chk("C_vld", 32'(bus.vld_out), 32'h0);
    bus.rd_en = '0;

    // D: invalid address 3, len 4 -> 5 beats dropped, one err pulse
    bus.d_in = 8'h13; bus.pkt_valid = 1'b1; #1;
    chk("D_busy", 32'(bus.busy), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) beat(8'h30 + 8'(k), 1'b1);
    chk("D_err4", 32'(bus.err), 32'h0);
    beat(8'h00, 1'b0);
    idle();
    chk("D_err5", 32'(bus.err), 32'h1);
    chk("D_vld", 32'(bus.vld_out), 32'h0);
    tick();
    chk("D_err6", 32'(bus.err), 32'h0);

    // E: channel 2 never read -> flushed at edge TMO+1 after vld rises
    beat(8'h0A, 1'b1);
    chk("E_vld0", 32'(bus.vld_out), 32'h4);
    beat(8'h55, 1'b1);
    beat(8'h66, 1'b1);
    beat(8'h39, 1'b0);
    idle();
    chk("E_err", 32'(bus.err), 32'h0);
    repeat (36) tick();
    beat(8'h00, 1'b1);
    beat(8'h00, 1'b0);
    idle();
    repeat (39) tick();
    chk("E_vld80", 32'(bus.vld_out), 32'h5);
    tick();
    chk("E_vld81", 32'(bus.vld_out), 32'h1);
    chk("E_dout2", 32'(bus.dout[23:16]), 32'h0);
    bus.rd_en = 3'b001;
    tick();
    chk("E_rd0", 32'(bus.dout[7:0]), 32'h00);
    tick();
    chk("E_vldend", 32'(bus.vld_out), 32'h0);
    bus.rd_en = '0;

    // F: reset mid-payload, then a normal packet
    beat(8'h20, 1'b1);
    beat(8'h10, 1'b1);
    beat(8'h11, 1'b1);
    bus.d_in = 8'h12;
    #2 rst = 1'b0;
    #1;
    chk("F_vld",  32'(bus.vld_out), 32'h0);
    chk("F_busy", 32'(bus.busy),    32'h0);
    chk("F_err",  32'(bus.err),     32'h0);
    chk("F_dout", 32'(bus.dout),    32'h0);
    idle();
    #1 rst = 1'b1;
    tick();
    beat(8'h04, 1'b1);
    beat(8'h77, 1'b1);
    beat(8'h73, 1'b0);
    idle();
    chk("F_err2", 32'(bus.err), 32'h0);
    bus.rd_en = 3'b001;
    tick();
    chk("F_d0", 32'(bus.dout[7:0]), 32'h04);
    tick();
    chk("F_d1", 32'(bus.dout[7:0]), 32'h77);
    tick();
    chk("F_d2", 32'(bus.dout[7:0]), 32'h73);
    chk("F_vld3", 32'(bus.vld_out), 32'h0);
    bus.rd_en = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
